// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the timer sequencer: register addresses, control and
// status bit positions, FSM state encoding and register packing helpers.
package timer_sequencer_pkg;

  // Default register map
  localparam logic [31:0] CNT_CTRL_ADDR_DEF = 32'h0000_010C;
  localparam logic [31:0] SEQ_CTRL_ADDR_DEF = 32'h0000_0110;
  localparam logic [31:0] SEQ_STAT_ADDR_DEF = 32'h0000_0114;

  // Interval counter control register bits
  localparam int CNT_START_BIT = 0;
  localparam int CNT_DONE_BIT  = 1;

  // SEQ_CTRL bits
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_N_LSB     = 8;

  // SEQ_STAT bits
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_ERR_BIT     = 2;
  localparam int STAT_ABORTED_BIT = 3;
  localparam int STAT_CNT_LSB     = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_CLR = 3'd2,
    ST_GAP      = 3'd3,
    ST_POLL     = 3'd4,
    ST_NEXT     = 3'd5,
    ST_FIN      = 3'd6
  } seq_state_e;

  // Build the SEQ_STAT read value
  function automatic logic [31:0] pack_stat(input logic       busy,
                                            input logic       done,
                                            input logic       err,
                                            input logic       aborted,
                                            input logic [7:0] count);
    logic [31:0] v;
    v = 32'h0000_0000;
    v[STAT_BUSY_BIT]       = busy;
    v[STAT_DONE_BIT]       = done;
    v[STAT_ERR_BIT]        = err;
    v[STAT_ABORTED_BIT]    = aborted;
    v[STAT_CNT_LSB +: 8]   = count;
    return v;
  endfunction

  // Build the SEQ_CTRL read value (start/abort are self-clearing and read 0)
  function automatic logic [31:0] pack_ctrl(input logic [7:0] n);
    logic [31:0] v;
    v = 32'h0000_0000;
    v[CTRL_N_LSB +: 8] = n;
    return v;
  endfunction

endpackage

// File: rtl/timer_sequencer_seq_bus_mux.sv
// seq_bus_mux: combinational arbiter between the CPU data port and the
// sequencer's own bus master, plus the CPU read-data select.
// Ports:
//  cpu_req/cpu_address/cpu_dataout/cpu_we  CPU access request
//  seq_req/seq_address/seq_dataout/seq_we  sequencer access request
//  seq_ctrl_rd/seq_stat_rd                 sequencer register read values
//  bus_datain                              peripheral read data
//  address/Dataout/WE                      peripheral bus outputs
//  cpu_datain                              read data to CPU
//  seq_grant                               sequencer owns the bus this cycle
module seq_bus_mux
  import timer_sequencer_pkg::*;
#(
  parameter logic [31:0] SEQ_CTRL_ADDR = SEQ_CTRL_ADDR_DEF,
  parameter logic [31:0] SEQ_STAT_ADDR = SEQ_STAT_ADDR_DEF
) (
  input  logic        cpu_req,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_dataout,
  input  logic        cpu_we,
  input  logic        seq_req,
  input  logic [31:0] seq_address,
  input  logic [31:0] seq_dataout,
  input  logic        seq_we,
  input  logic [31:0] seq_ctrl_rd,
  input  logic [31:0] seq_stat_rd,
  input  logic [31:0] bus_datain,
  output logic [31:0] address,
  output logic [31:0] Dataout,
  output logic        WE,
  output logic [31:0] cpu_datain,
  output logic        seq_grant
);

  logic hit_ctrl_s;
  logic hit_stat_s;

  assign hit_ctrl_s = (cpu_address == SEQ_CTRL_ADDR);
  assign hit_stat_s = (cpu_address == SEQ_STAT_ADDR);

  // Bus owner select: CPU has fixed priority; sequencer registers stay off the bus
  always_comb begin
    address   = 32'h0000_0000;
    Dataout   = 32'h0000_0000;
    WE        = 1'b0;
    seq_grant = 1'b0;
    if (cpu_req) begin
      if (hit_ctrl_s || hit_stat_s) begin
        address = 32'h0000_0000;
        Dataout = 32'h0000_0000;
        WE      = 1'b0;
      end else begin
        address = cpu_address;
        Dataout = cpu_dataout;
        WE      = cpu_we;
      end
    end else if (seq_req) begin
      address   = seq_address;
      Dataout   = seq_dataout;
      WE        = seq_we;
      seq_grant = 1'b1;
    end else begin
      seq_grant = 1'b0;
    end
  end

  // CPU read data: local registers when addressed, peripheral data otherwise
  always_comb begin
    cpu_datain = bus_datain;
    if (hit_ctrl_s) begin
      cpu_datain = seq_ctrl_rd;
    end else if (hit_stat_s) begin
      cpu_datain = seq_stat_rd;
    end else begin
      cpu_datain = bus_datain;
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: bus master that runs N back-to-back intervals of the
// interval counter (start, wait for start to clear, poll done, restart) while
// sharing the peripheral bus with the CPU, which always wins arbitration.
// Ports:
//  clk, rst                               clock, synchronous active-high reset
//  cpu_req/cpu_address/cpu_dataout/cpu_we CPU data port
//  cpu_datain                             CPU read data
//  address/Dataout/WE/bus_datain          peripheral bus
//  irq                                    1-cycle pulse on finish, error, abort
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter logic [31:0] CNT_CTRL_ADDR = CNT_CTRL_ADDR_DEF,
  parameter logic [31:0] SEQ_CTRL_ADDR = SEQ_CTRL_ADDR_DEF,
  parameter logic [31:0] SEQ_STAT_ADDR = SEQ_STAT_ADDR_DEF,
  parameter int          POLL_GAP      = 16,
  parameter logic [31:0] TIMEOUT       = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_dataout,
  input  logic        cpu_we,
  output logic [31:0] cpu_datain,
  output logic [31:0] address,
  output logic [31:0] Dataout,
  output logic        WE,
  input  logic [31:0] bus_datain,
  output logic        irq
);

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  seq_state_e  state_r, state_nxt_s;
  logic [7:0]  n_r, n_nxt_s;
  logic [7:0]  count_r, count_nxt_s;
  logic        done_r, done_nxt_s;
  logic        err_r, err_nxt_s;
  logic        aborted_r, aborted_nxt_s;
  logic [15:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [31:0] tmr_r, tmr_nxt_s;
  logic        irq_r, irq_nxt_s;

  logic        ctrl_wr_s;
  logic        wr_start_s;
  logic        wr_abort_s;
  logic [7:0]  wr_n_s;
  logic        seq_req_s;
  logic        seq_we_s;
  logic        seq_grant_s;
  logic        timeout_s;
  logic [7:0]  count_inc_s;
  logic [31:0] ctrl_rd_s;
  logic [31:0] stat_rd_s;

  assign ctrl_wr_s   = cpu_req && cpu_we && (cpu_address == SEQ_CTRL_ADDR);
  assign wr_start_s  = ctrl_wr_s && cpu_dataout[CTRL_START_BIT];
  assign wr_abort_s  = ctrl_wr_s && cpu_dataout[CTRL_ABORT_BIT];
  assign wr_n_s      = cpu_dataout[CTRL_N_LSB +: 8];
  assign seq_req_s   = (state_r == ST_ARM) || (state_r == ST_WAIT_CLR) || (state_r == ST_POLL);
  assign seq_we_s    = (state_r == ST_ARM);
  assign timeout_s   = (tmr_r >= TIMEOUT);
  assign count_inc_s = count_r + 8'd1;
  assign ctrl_rd_s   = pack_ctrl(n_r);
  assign stat_rd_s   = pack_stat(state_r != ST_IDLE, done_r, err_r, aborted_r, count_r);
  assign irq         = irq_r;

  seq_bus_mux #(
    .SEQ_CTRL_ADDR(SEQ_CTRL_ADDR),
    .SEQ_STAT_ADDR(SEQ_STAT_ADDR)
  ) u_mux (
    .cpu_req    (cpu_req),
    .cpu_address(cpu_address),
    .cpu_dataout(cpu_dataout),
    .cpu_we     (cpu_we),
    .seq_req    (seq_req_s),
    .seq_address(CNT_CTRL_ADDR),
    .seq_dataout(32'h0000_0001),
    .seq_we     (seq_we_s),
    .seq_ctrl_rd(ctrl_rd_s),
    .seq_stat_rd(stat_rd_s),
    .bus_datain (bus_datain),
    .address    (address),
    .Dataout    (Dataout),
    .WE         (WE),
    .cpu_datain (cpu_datain),
    .seq_grant  (seq_grant_s)
  );

  // Next-state and register-update logic for the sequencer FSM
  always_comb begin
    state_nxt_s   = state_r;
    n_nxt_s       = n_r;
    count_nxt_s   = count_r;
    done_nxt_s    = done_r;
    err_nxt_s     = err_r;
    aborted_nxt_s = aborted_r;
    gap_cnt_nxt_s = gap_cnt_r;
    irq_nxt_s     = 1'b0;
    // interval timer saturates rather than wrapping back under TIMEOUT
    tmr_nxt_s     = (tmr_r == 32'hFFFF_FFFF) ? tmr_r : (tmr_r + 32'd1);

    if ((state_r != ST_IDLE) && wr_abort_s) begin
      // abort leaves the counter as it is: no cleanup write
      state_nxt_s   = ST_IDLE;
      aborted_nxt_s = 1'b1;
      irq_nxt_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_start_s && !wr_abort_s) begin
            n_nxt_s       = wr_n_s;
            count_nxt_s   = 8'd0;
            done_nxt_s    = 1'b0;
            err_nxt_s     = 1'b0;
            aborted_nxt_s = 1'b0;
            if (wr_n_s != 8'd0) begin
              state_nxt_s = ST_ARM;
            end else begin
              done_nxt_s = 1'b1;
              irq_nxt_s  = 1'b1;
            end
          end else if (ctrl_wr_s) begin
            n_nxt_s = wr_n_s;
          end else begin
            n_nxt_s = n_r;
          end
        end
        ST_ARM: begin
          tmr_nxt_s = 32'd0;
          if (seq_grant_s) begin
            state_nxt_s = ST_WAIT_CLR;
          end else begin
            state_nxt_s = ST_ARM;
          end
        end
        ST_WAIT_CLR: begin
          if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            err_nxt_s   = 1'b1;
            irq_nxt_s   = 1'b1;
          end else if (seq_grant_s && (bus_datain[CNT_DONE_BIT:CNT_START_BIT] == 2'b00)) begin
            state_nxt_s   = ST_GAP;
            gap_cnt_nxt_s = 16'd0;
          end else begin
            state_nxt_s = ST_WAIT_CLR;
          end
        end
        ST_GAP: begin
          if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            err_nxt_s   = 1'b1;
            irq_nxt_s   = 1'b1;
          end else if (gap_cnt_r >= GAP_LAST) begin
            state_nxt_s = ST_POLL;
          end else begin
            gap_cnt_nxt_s = gap_cnt_r + 16'd1;
          end
        end
        ST_POLL: begin
          if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            err_nxt_s   = 1'b1;
            irq_nxt_s   = 1'b1;
          end else if (seq_grant_s) begin
            if (bus_datain[CNT_DONE_BIT]) begin
              state_nxt_s = ST_NEXT;
            end else begin
              state_nxt_s   = ST_GAP;
              gap_cnt_nxt_s = 16'd0;
            end
          end else begin
            state_nxt_s = ST_POLL;
          end
        end
        ST_NEXT: begin
          count_nxt_s = count_inc_s;
          if (count_inc_s == n_r) begin
            state_nxt_s = ST_FIN;
          end else begin
            state_nxt_s = ST_ARM;
          end
        end
        ST_FIN: begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
          irq_nxt_s   = 1'b1;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and register storage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      n_r       <= 8'd0;
      count_r   <= 8'd0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      aborted_r <= 1'b0;
      gap_cnt_r <= 16'd0;
      tmr_r     <= 32'd0;
      irq_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      n_r       <= n_nxt_s;
      count_r   <= count_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      aborted_r <= aborted_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      tmr_r     <= tmr_nxt_s;
      irq_r     <= irq_nxt_s;
    end
  end

endmodule
